// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: opcodes, reset PC and fetch FSM encoding.
package mips_pkg;

    // Opcodes decoded by the main control unit
    localparam logic [5:0] OPC_RTYPE  = 6'b000000;
    localparam logic [5:0] OPC_LW     = 6'b100011;
    localparam logic [5:0] OPC_ADDI   = 6'b001000;
    localparam logic [5:0] OPC_ANDI   = 6'b001100;
    localparam logic [5:0] OPC_ORI    = 6'b001101;
    localparam logic [5:0] OPC_XORI   = 6'b001110;
    localparam logic [5:0] OPC_SLTI   = 6'b001010;
    localparam logic [5:0] OPC_SEQ    = 6'b011000;

    // Bubble opcode: falls into the control unit's no-op default.
    // Never use OPC_RTYPE here, R-type sets regWrite.
    localparam logic [5:0] OPC_BUBBLE = 6'b111111;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetchState_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched word that decode could not accept.
module if_skid_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [DATA_W-1:0] loadInstr,
    input  logic [ADDR_W-1:0] loadPc,
    output logic              full,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc
);

    // Entry register; clear wins over load so a redirect always empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= loadInstr;
            pc    <= loadPc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem requests, IF/ID register
// with stall skid and redirect squash.
module if_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_rvalid,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc_plus4,
    output logic [5:0]        opcode
);

    fetchState_t       state, stateNxt;
    logic [ADDR_W-1:0] pc, pcNxt;
    logic              discard, discardNxt;

    logic              loadFromMem, loadFromSkid;
    logic              skidLoad, skidClear;
    logic              skidFull;
    logic [DATA_W-1:0] skidInstr;
    logic [ADDR_W-1:0] skidPc;

    logic [ADDR_W-1:0] pcPlus4, skidPcPlus4, redirectAligned;

    assign pcPlus4         = pc + ADDR_W'(4);
    assign skidPcPlus4     = skidPc + ADDR_W'(4);
    assign redirectAligned = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Request is held low while in reset so the memory never sees a strobe it cannot answer
    assign imem_req  = rst_n && (state == S_FETCH);
    assign imem_addr = pc;

    // Bubbles must decode as no-op, not R-type
    assign opcode = if_id_valid ? if_id_instr[31:26] : OPC_BUBBLE;

    if_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) uSkid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skidLoad),
        .unload    (loadFromSkid),
        .clear     (skidClear),
        .loadInstr (imem_rdata),
        .loadPc    (pc),
        .full      (skidFull),
        .instr     (skidInstr),
        .pc        (skidPc)
    );

    // FSM, PC and discard-flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            discard <= 1'b0;
        end else begin
            state   <= stateNxt;
            pc      <= pcNxt;
            discard <= discardNxt;
        end
    end

    // Next state, PC update and IF/ID / skid load decisions; redirect overrides everything
    always_comb begin
        stateNxt     = state;
        pcNxt        = pc;
        discardNxt   = discard;
        loadFromMem  = 1'b0;
        loadFromSkid = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;

        if (redirect_valid) begin
            pcNxt     = redirectAligned;
            skidClear = 1'b1;
            unique case (state)
                S_FETCH: begin
                    // request to the old PC is already out; drop its answer
                    stateNxt   = S_WAIT;
                    discardNxt = 1'b1;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        stateNxt   = S_FETCH;
                        discardNxt = 1'b0;
                    end else begin
                        stateNxt   = S_WAIT;
                        discardNxt = 1'b1;
                    end
                end
                default: begin
                    stateNxt   = S_FETCH;
                    discardNxt = 1'b0;
                end
            endcase
        end else begin
            unique case (state)
                S_FETCH: stateNxt = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discardNxt = 1'b0;
                            stateNxt   = S_FETCH;
                        end else if (!stall || !if_id_valid) begin
                            loadFromMem = 1'b1;
                            pcNxt       = pcPlus4;
                            stateNxt    = S_FETCH;
                        end else begin
                            skidLoad = 1'b1;
                            pcNxt    = pcPlus4;
                            stateNxt = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (!stall && skidFull) begin
                        loadFromSkid = 1'b1;
                        stateNxt     = S_FETCH;
                    end
                end
            endcase
        end
    end

    // IF/ID pipeline register: squash on redirect, hold on stall, bubble otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid    <= 1'b0;
            if_id_instr    <= '0;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            if_id_valid <= 1'b0;
        end else if (loadFromMem) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= imem_rdata;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pcPlus4;
        end else if (loadFromSkid) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= skidInstr;
            if_id_pc       <= skidPc;
            if_id_pc_plus4 <= skidPcPlus4;
        end else if (!stall) begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small latency-programmable memory responder.
module tb_if_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [5:0]  opcode;

    int          errCnt = 0;
    int          chkCnt = 0;
    int          memLat;
    int          memCnt;
    logic [31:0] memAddr;
    logic        addrMode;

    if_stage #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_rvalid    (imem_rvalid),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .opcode         (opcode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (addrMode) return {6'b100011, a[25:0]};
        return 32'h2008_0005;
    endfunction

    // One clock: capture the request seen at the edge, then update the responder
    task automatic step();
        logic        reqS;
        logic [31:0] addrS;
        reqS  = imem_req;
        addrS = imem_addr;
        @(posedge clk);
        #1;
        if (memCnt > 0) memCnt--;
        if (reqS) begin
            memCnt  = memLat;
            memAddr = addrS;
        end
        imem_rvalid = (memCnt == 1);
        imem_rdata  = imem_rvalid ? memWord(memAddr) : 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rdata = 32'h0; imem_rvalid = 1'b0;
        memLat = 1; memCnt = 0; memAddr = 32'h0; addrMode = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  32'(if_id_valid), 32'h0);
        check("rst_instr",  if_id_instr, 32'h0);
        check("rst_pc",     if_id_pc, 32'h0);
        check("rst_plus4",  if_id_pc_plus4, 32'h0);
        check("rst_opcode", 32'(opcode), 32'h3F);

        // 1: reset release, zero-wait memory
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t1_req0",  32'(imem_req), 32'h1);
        check("t1_addr0", imem_addr, 32'h0);
        step();
        check("t1_wait_req", 32'(imem_req), 32'h0);
        step();
        check("t1_valid", 32'(if_id_valid), 32'h1);
        check("t1_instr", if_id_instr, 32'h2008_0005);
        check("t1_pc",    if_id_pc, 32'h0);
        check("t1_plus4", if_id_pc_plus4, 32'h4);
        check("t1_opc",   32'(opcode), 32'h08);
        check("t1_req1",  32'(imem_req), 32'h1);
        check("t1_addr1", imem_addr, 32'h4);

        // 2: stall with a response arriving -> skid/HOLD
        addrMode = 1'b1;
        step();
        check("t2_bubble",     32'(if_id_valid), 32'h0);
        check("t2_bubble_opc", 32'(opcode), 32'h3F);
        step();
        check("t2_pc4",    if_id_pc, 32'h4);
        check("t2_instr4", if_id_instr, 32'h8C00_0004);
        stall = 1'b1;
        step();
        check("t2_hold_valid", 32'(if_id_valid), 32'h1);
        check("t2_hold_pc",    if_id_pc, 32'h4);
        step();
        check("t2_state_hold", 32'(dut.state), 32'(S_HOLD));
        check("t2_hold_pc2",   if_id_pc, 32'h4);
        check("t2_hold_req",   32'(imem_req), 32'h0);
        step();
        check("t2_hold_req2",  32'(imem_req), 32'h0);
        check("t2_hold_pc3",   if_id_pc, 32'h4);
        stall = 1'b0;
        step();
        check("t2_pc8",    if_id_pc, 32'h8);
        check("t2_instr8", if_id_instr, 32'h8C00_0008);
        check("t2_plus4",  if_id_pc_plus4, 32'hC);
        check("t2_req",    32'(imem_req), 32'h1);
        check("t2_addr",   imem_addr, 32'hC);

        // 3: redirect while a response is pending (latency 2)
        memLat = 2;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        step();
        redirect_valid = 1'b0;
        check("t3_valid0", 32'(if_id_valid), 32'h0);
        check("t3_noreq",  32'(imem_req), 32'h0);
        step();
        check("t3_valid1", 32'(if_id_valid), 32'h0);
        check("t3_opc",    32'(opcode), 32'h3F);
        check("t3_req",    32'(imem_req), 32'h1);
        check("t3_addr",   imem_addr, 32'h0000_0040);
        memLat = 1;

        // 4: redirect in FETCH
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        check("t4_noreq", 32'(imem_req), 32'h0);
        check("t4_opc0",  32'(opcode), 32'h3F);
        step();
        check("t4_valid", 32'(if_id_valid), 32'h0);
        check("t4_opc1",  32'(opcode), 32'h3F);
        check("t4_req",   32'(imem_req), 32'h1);
        check("t4_addr",  imem_addr, 32'h0000_0100);
        step();
        check("t4_opc2",  32'(opcode), 32'h3F);
        step();
        check("t4_lvalid", 32'(if_id_valid), 32'h1);
        check("t4_lpc",    if_id_pc, 32'h0000_0100);
        check("t4_linstr", if_id_instr, 32'h8C00_0100);

        // 5: wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check("t5_req",  32'(imem_req), 32'h1);
        check("t5_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        step();
        check("t5_pc",    if_id_pc, 32'hFFFF_FFFC);
        check("t5_instr", if_id_instr, 32'h8FFF_FFFC);
        check("t5_plus4", if_id_pc_plus4, 32'h0);
        check("t5_naddr", imem_addr, 32'h0);
        check("t5_nreq",  32'(imem_req), 32'h1);

        // 6: async reset mid-WAIT, 3-cycle memory
        memLat = 3;
        step();
        step();
        check("t6_in_wait", 32'(dut.state), 32'(S_WAIT));
        #2;
        rst_n = 1'b0; memCnt = 0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1;
        check("t6_valid",  32'(if_id_valid), 32'h0);
        check("t6_instr",  if_id_instr, 32'h0);
        check("t6_pc",     if_id_pc, 32'h0);
        check("t6_plus4",  if_id_pc_plus4, 32'h0);
        check("t6_opc",    32'(opcode), 32'h3F);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_req",  32'(imem_req), 32'h1);
        check("t6_addr", imem_addr, 32'h0);
        step();
        step();
        step();
        check("t6_not_yet", 32'(if_id_valid), 32'h0);
        step();
        check("t6_lvalid", 32'(if_id_valid), 32'h1);
        check("t6_lpc",    if_id_pc, 32'h0);
        check("t6_linstr", if_id_instr, 32'h8C00_0000);
        check("t6_lopc",   32'(opcode), 32'h23);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage directly upstream of the main control decoder.
- Holds the PC and issues single-outstanding requests to a variable-latency instruction memory.
- Captures each returned word into the IF/ID pipeline register and drives the 6-bit opcode consumed by the control unit.
- Supports decode stall (via a one-entry skid buffer) and branch/jump redirect with in-flight response discard.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request strobe, one cycle per fetch.
- imem_addr  out  ADDR_W  word address, valid with imem_req.
- imem_rdata  in  DATA_W  returned instruction.
- imem_rvalid  in  1  response strobe; exactly one per request, at least 1 cycle after it.
- stall  in  1  decode cannot accept; IF/ID register holds.
- redirect_valid  in  1  branch/jump taken; squash and refetch.
- redirect_pc  in  ADDR_W  new PC.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_instr  out  DATA_W  registered instruction.
- if_id_pc  out  ADDR_W  address of if_id_instr.
- if_id_pc_plus4  out  ADDR_W  if_id_pc + 4, for branch target calculation.
- opcode  out  6  if_id_instr[31:26] when valid, else 6'b111111.

Behaviour:
Clock and reset (already decided):
- One clock domain, clk. Reset rst_n is asynchronous, active-low.
- On reset: pc=RESET_PC, state=FETCH, discard=0, skid empty.
- Reset values: if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0, opcode=6'b111111.
- imem_req asserts in the first cycle after rst_n rises.

State machine (FETCH, WAIT, HOLD):
- FETCH: imem_req=1, imem_addr=pc (combinational). Next state is WAIT. imem_rvalid is ignored in FETCH.
- WAIT: imem_req=0. On imem_rvalid:
  - If discard=1: drop the data, clear discard, go to FETCH.
  - Else if stall=0 or if_id_valid=0: load the IF/ID register with {1, rdata, pc, pc+4}, set pc<=pc+4, go to FETCH.
  - Else: load the skid buffer with {rdata, pc}, set pc<=pc+4, go to HOLD.
- HOLD: imem_req=0. When stall=0, move the skid contents into the IF/ID register, go to FETCH.

IF/ID register:
- When stall=0 and nothing is loaded this cycle, if_id_valid<=0 (bubble).
- When stall=1, all IF/ID fields hold.

Redirect (highest priority, overrides stall):
- if_id_valid<=0 and the skid buffer is cleared.
- pc<={redirect_pc[ADDR_W-1:2],2'b00}.
- From FETCH (the request to the old address is already out): go to WAIT with discard=1.
- From WAIT without rvalid the same cycle: stay in WAIT with discard=1.
- From WAIT with rvalid the same cycle: drop the data, go to FETCH.
- From HOLD: go to FETCH.

Latency:
- Request to IF/ID valid is memory latency + 1 cycle.
- Zero-wait memory (rvalid 1 cycle after req) gives one instruction every 2 cycles.

Arithmetic:
- pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).

Opcode gating:
- opcode is combinational from the IF/ID register.
- Bubbles output 6'b111111 so the control unit falls into its no-op default. Opcode 0 is R-type with regWrite=1, so it must never be used as a bubble.

Reset mid-operation:
- Everything returns to reset values.
- The memory is reset by the same rst_n, so no stale response is expected.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants: OPC_RTYPE, OPC_LW, OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_SLTI, OPC_SEQ.
  - OPC_BUBBLE=6'b111111.
  - RESET_PC default.
  - Fetch state encoding.
- One sub-module, if_skid_buf: one-entry holding register with load/unload/clear and a full flag.

Test Plan:
1. Reset release, memory returns 32'h2008_0005 one cycle after each req:
   - Required: first req at addr 0.
   - Required: if_id_valid=1 with instr 32'h2008_0005, pc 0, pc_plus4 4, opcode 6'b001000.
   - Required: next req at addr 4.
2. Stall: stall=1 while if_id_valid=1 and a response at pc 8 arrives:
   - Required: IF/ID holds pc 4 and the state enters HOLD.
   - Required: on the cycle after stall drops, IF/ID shows pc 8; no request is issued while in HOLD.
3. Redirect in WAIT: redirect_valid with redirect_pc=32'h0000_0043 while a response is pending:
   - Required: the pending response is discarded and if_id_valid=0.
   - Required: the next req uses addr 32'h0000_0040 (low bits forced to zero).
4. Redirect in FETCH:
   - Required: the response to the old address is dropped.
   - Required: the following req is to the redirect target.
   - Required: opcode=6'b111111 throughout the bubble.
5. Wrap: redirect to 32'hFFFF_FFFC:
   - Required: if_id_pc_plus4=0.
   - Required: the next imem_addr=0.
6. Async reset mid-WAIT with 3-cycle memory latency:
   - Required: all outputs go to reset values immediately, before the next clk edge.
   - Required: imem_req reasserts at RESET_PC after rst_n rises.
